// File: rtl/lcd_line_fetch.sv
// lcd_line_fetch
//   Pulls source lines out of the SDRAM read-port FIFO into a ping-pong line
//   buffer (2 x SRC_W words). It serves LCD pixel requests with integer
//   nearest-neighbour upscaling: each source pixel is repeated SCALE_X times
//   and each source line is shown SCALE_Y times.
//
//   Optional feature: define LCD_FETCH_MIRROR_EN to add the h_mirror input.
//   h_mirror is sampled on line_start and, when set, reverses the line
//   horizontally. When the macro is undefined, the port does not exist.
//
// Ports
//   clk          in   pixel clock, also the FIFO read clock
//   rst          in   synchronous, active-high reset
//   frame_start  in   1-cycle pulse at vsync; restarts the fetch sequence
//   line_start   in   1-cycle pulse before each output line
//   pix_req      in   request the next output pixel
//   h_mirror     in   (LCD_FETCH_MIRROR_EN only) mirror this line
//   pix_data     out  pixel value, valid with pix_valid
//   pix_valid    out  pix_req delayed by one cycle
//   fifo_rd_en   out  FIFO read enable (the FIFO has a 1-cycle read latency)
//   fifo_rd_data in   FIFO read data
//   fifo_load    out  FIFO reload strobe, held for LOAD_CYC cycles
//   read_valid   out  SDRAM read-side enable for the FIFO
//   underrun     out  sticky flag: a line needed new data that was not ready
module lcd_line_fetch #(
  parameter int DATA_W    = 16,
  parameter int SRC_W     = 400,
  parameter int SRC_H     = 240,
  parameter int SCALE_X   = 2,
  parameter int SCALE_Y   = 2,
  parameter int LOAD_CYC  = 4,
  parameter int PRIME_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              pix_req,
`ifdef LCD_FETCH_MIRROR_EN
  input  logic              h_mirror,
`endif
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_load,
  output logic              read_valid,
  output logic              underrun
);

  localparam int AW   = $clog2(SRC_W);
  localparam int MW   = $clog2(2 * SRC_W);
  localparam int LW   = $clog2(SRC_H + 1);
  localparam int CMAX = (LOAD_CYC > PRIME_CYC) ? LOAD_CYC : PRIME_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int XRW  = $clog2(SCALE_X + 1);
  localparam int YRW  = $clog2(SCALE_Y + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRIME,
    S_FILL,
    S_WAIT
  } state_t;

  state_t            state;
  logic [CW-1:0]     cyc_cnt;
  logic              rd_en;
  logic [AW-1:0]     rd_cnt;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [LW-1:0]     src_line;
  logic              fill_bank;
  logic [1:0]        bank_full;

  logic              first_line;
  logic [YRW-1:0]    rep_cnt;
  logic [AW-1:0]     x_src;
  logic [XRW-1:0]    x_rep;
  logic              line_done;

  logic [DATA_W-1:0] mem [0:2*SRC_W-1];

  logic              fill_done;
  logic              fill_full_now;
  logic              rep_last;
  logic              do_swap;
  logic [AW-1:0]     rd_addr;
  logic [MW-1:0]     rd_idx;
  logic [MW-1:0]     wr_idx;

  // The last word lands this cycle; a swap in the same cycle may use it.
  assign fill_done     = wr_en && (wr_addr == AW'(SRC_W - 1));
  assign fill_full_now = bank_full[fill_bank] | fill_done;
  assign rep_last      = (rep_cnt == YRW'(SCALE_Y - 1));
  assign do_swap       = line_start && !frame_start
                         && (rep_last || first_line) && fill_full_now;

  // A frame restart must stop reads in the very cycle it arrives.
  assign fifo_rd_en = rd_en & ~frame_start;

`ifdef LCD_FETCH_MIRROR_EN
  logic mirror;
  assign rd_addr = mirror ? (AW'(SRC_W - 1) - x_src) : x_src;
`else
  assign rd_addr = x_src;
`endif

  // The display bank is always the one not being filled.
  assign rd_idx = fill_bank ? MW'(rd_addr) : (MW'(SRC_W) + MW'(rd_addr));
  assign wr_idx = fill_bank ? (MW'(SRC_W) + MW'(wr_addr)) : MW'(wr_addr);

  // ---- fill side: FIFO control and bank bookkeeping ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cyc_cnt    <= '0;
      rd_en      <= 1'b0;
      rd_cnt     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      src_line   <= '0;
      fill_bank  <= 1'b0;
      bank_full  <= 2'b00;
      fifo_load  <= 1'b0;
      read_valid <= 1'b0;
    end else if (frame_start) begin
      state      <= S_LOAD;
      cyc_cnt    <= '0;
      rd_en      <= 1'b0;
      rd_cnt     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      src_line   <= '0;
      fill_bank  <= 1'b0;
      bank_full  <= 2'b00;
      fifo_load  <= 1'b1;
      read_valid <= 1'b0;
    end else begin
      wr_en <= rd_en;
      if (wr_en) begin
        wr_addr <= fill_done ? '0 : wr_addr + 1'b1;
      end

      case (state)
        S_IDLE: ;
        S_LOAD: begin
          if (cyc_cnt == CW'(LOAD_CYC - 1)) begin
            cyc_cnt    <= '0;
            fifo_load  <= 1'b0;
            read_valid <= 1'b1;
            state      <= S_PRIME;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_PRIME: begin
          if (cyc_cnt == CW'(PRIME_CYC - 1)) begin
            cyc_cnt <= '0;
            rd_en   <= 1'b1;
            rd_cnt  <= '0;
            wr_addr <= '0;
            state   <= S_FILL;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_FILL: begin
          if (rd_en) begin
            if (rd_cnt == AW'(SRC_W - 1)) begin
              rd_en  <= 1'b0;
              rd_cnt <= '0;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
          if (fill_done) begin
            src_line <= src_line + 1'b1;
            if ((src_line + LW'(1)) < LW'(SRC_H)) begin
              state <= S_WAIT;
            end else begin
              state      <= S_IDLE;
              read_valid <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (!bank_full[fill_bank]) begin
            rd_en   <= 1'b1;
            rd_cnt  <= '0;
            wr_addr <= '0;
            state   <= S_FILL;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (fill_done) begin
        bank_full[fill_bank] <= 1'b1;
      end
      // The filled bank becomes the display bank; the old one is refilled.
      if (do_swap) begin
        fill_bank             <= ~fill_bank;
        bank_full[~fill_bank] <= 1'b0;
      end
    end
  end

  // ---- line buffer write (data path, no reset) ----
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= fifo_rd_data;
    end
  end

  // ---- display side: line repeat, pixel repeat, pixel output ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      underrun   <= 1'b0;
      first_line <= 1'b0;
      rep_cnt    <= '0;
      x_src      <= '0;
      x_rep      <= '0;
      line_done  <= 1'b0;
`ifdef LCD_FETCH_MIRROR_EN
      mirror     <= 1'b0;
`endif
    end else begin
      pix_valid <= pix_req;
      if (pix_req) begin
        pix_data <= line_done ? '0 : mem[rd_idx];
      end

      if (frame_start) begin
        underrun   <= 1'b0;
        first_line <= 1'b1;
        rep_cnt    <= '0;
        x_src      <= '0;
        x_rep      <= '0;
        line_done  <= 1'b0;
      end else if (line_start) begin
        x_src     <= '0;
        x_rep     <= '0;
        line_done <= 1'b0;
`ifdef LCD_FETCH_MIRROR_EN
        mirror    <= h_mirror;
`endif
        if (rep_last || first_line) begin
          if (fill_full_now) begin
            rep_cnt    <= '0;
            first_line <= 1'b0;
          end else if (state != S_IDLE) begin
            // Keep rep_cnt/first_line so the next line retries the swap.
            // Once the frame is fully fetched (IDLE), repeating is expected.
            underrun <= 1'b1;
          end
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end else if (pix_req && !line_done) begin
        if (x_rep == XRW'(SCALE_X - 1)) begin
          x_rep <= '0;
          if (x_src == AW'(SRC_W - 1)) begin
            line_done <= 1'b1;
          end else begin
            x_src <= x_src + 1'b1;
          end
        end else begin
          x_rep <= x_rep + 1'b1;
        end
      end
    end
  end

endmodule
